// File: rtl/oven_pkg.sv
// Shared types and constants for the oven cook timer.
package oven_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] BCD_MAX      = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;

  // Entry order of the digits as keyed by the user.
  localparam logic [1:0] DIG_MIN_TENS = 2'd0;
  localparam logic [1:0] DIG_MIN_ONES = 2'd1;
  localparam logic [1:0] DIG_SEC_TENS = 2'd2;
  localparam logic [1:0] DIG_SEC_ONES = 2'd3;

  // Limit a keyed value to what the addressed digit can legally hold.
  function automatic logic [3:0] clamp_digit(input logic [3:0] v, input logic [1:0] pos);
    logic [3:0] lim;
    lim = (pos == DIG_SEC_TENS) ? SEC_TENS_MAX : BCD_MAX;
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/oven_debounce.sv
// Synchronizer plus stability filter for one asynchronous switch input.
// The output only follows the input once it has held steady for CYCLES clocks.
module oven_debounce #(
  parameter int unsigned CYCLES    = 1_000_000,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // Two-flop sync, then count consecutive cycles of disagreement before accepting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= RESET_VAL;
      s2   <= RESET_VAL;
      dout <= RESET_VAL;
      cnt  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 != dout) begin
        if (cnt == CW'(CYCLES - 1)) begin
          dout <= s2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/oven_cook_controller.sv
// Oven cook timer sequencer: MM:SS digit entry, 1 Hz BCD countdown,
// heater/alarm control. Define OVEN_DEBOUNCE_EN to filter the switch inputs.
module oven_cook_controller
  import oven_pkg::*;
#(
  parameter int unsigned TICK_DIV        = 50_000_000,
  parameter int unsigned DONE_SECONDS    = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  input  logic       pushButton,
  input  logic       onOff,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       heater_on,
  output logic       alarm,
  output logic [2:0] state_o,
  output logic [1:0] entry_pos
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DONE_SECONDS > 1) ? $clog2(DONE_SECONDS) : 1;

  state_t          state, state_n;
  logic [3:0][3:0] dig, dig_n, dec;   // [3]=min_tens .. [0]=sec_ones
  logic [1:0]      pos, pos_n;
  logic [PW-1:0]   presc;
  logic [DW-1:0]   done_cnt;
  logic            presc_clr;
  logic            btn_s, on_s, btn_q, on_q;
  logic            btn_pulse, on_rise, on_fall, btn_eff, tick;

`ifdef OVEN_DEBOUNCE_EN
  oven_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b0)) u_db_btn (
    .clk(clk), .rst_n(rst_n), .din(pushButton), .dout(btn_s)
  );
  oven_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_db_on (
    .clk(clk), .rst_n(rst_n), .din(onOff), .dout(on_s)
  );
`else
  logic btn_m, on_m;

  // Two-flop synchronizers; onOff resets high so a switch left on gives no start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      on_m  <= 1'b1;
      on_s  <= 1'b1;
    end else begin
      btn_m <= pushButton;
      btn_s <= btn_m;
      on_m  <= onOff;
      on_s  <= on_m;
    end
  end
`endif

  // Previous-cycle copies of the synchronized levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q <= 1'b0;
      on_q  <= 1'b1;
    end else begin
      btn_q <= btn_s;
      on_q  <= on_s;
    end
  end

  assign btn_pulse = btn_s & ~btn_q;
  assign on_rise   = on_s & ~on_q;
  assign on_fall   = ~on_s & on_q;
  // An onOff edge in the same cycle takes precedence; the key press is lost.
  assign btn_eff   = btn_pulse & ~on_rise & ~on_fall;
  assign tick      = (presc == PW'(TICK_DIV - 1)) && (state == ST_COOK || state == ST_DONE);

  // Prescaler: runs in COOK and DONE, frozen elsewhere, zeroed when cooking starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (presc_clr) begin
      presc <= '0;
    end else if (state == ST_COOK || state == ST_DONE) begin
      presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
    end
  end

  // Alarm duration counter, counts ticks spent in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (state != ST_DONE) begin
      done_cnt <= '0;
    end else if (tick) begin
      done_cnt <= done_cnt + 1'b1;
    end
  end

  // One-second BCD decrement of MM:SS with borrow chain.
  always_comb begin
    dec = dig;
    if (dig[0] != 4'd0) begin
      dec[0] = dig[0] - 4'd1;
    end else begin
      dec[0] = BCD_MAX;
      if (dig[1] != 4'd0) begin
        dec[1] = dig[1] - 4'd1;
      end else begin
        dec[1] = SEC_TENS_MAX;
        if (dig[2] != 4'd0) begin
          dec[2] = dig[2] - 4'd1;
        end else begin
          dec[2] = BCD_MAX;
          dec[3] = dig[3] - 4'd1;
        end
      end
    end
  end

  // Next-state, digit and entry-pointer logic.
  always_comb begin
    state_n   = state;
    dig_n     = dig;
    pos_n     = pos;
    presc_clr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (btn_eff) begin
          state_n = ST_ENTRY;
          dig_n   = '0;
          pos_n   = DIG_MIN_TENS;
        end
      end
      ST_ENTRY: begin
        if (on_rise && dig != '0) begin
          state_n   = ST_COOK;
          presc_clr = 1'b1;
        end else if (btn_eff) begin
          dig_n[2'd3 - pos] = clamp_digit(in, pos);
          pos_n             = pos + 2'd1;
        end
      end
      ST_COOK: begin
        if (on_fall) begin
          state_n = ST_PAUSE;
        end else if (tick) begin
          dig_n = dec;
          if (dig == 16'h0001) state_n = ST_DONE;
        end
      end
      ST_PAUSE: begin
        if (on_rise) begin
          state_n = ST_COOK;
        end else if (btn_eff) begin
          state_n = ST_IDLE;
          dig_n   = '0;
        end
      end
      ST_DONE: begin
        if (on_fall || btn_eff) begin
          state_n = ST_IDLE;
        end else if (tick && done_cnt == DW'(DONE_SECONDS - 1)) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State, digits and the registered heater/alarm drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dig       <= '0;
      pos       <= DIG_MIN_TENS;
      heater_on <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_n;
      dig       <= dig_n;
      pos       <= pos_n;
      heater_on <= (state == ST_COOK);
      alarm     <= (state == ST_DONE);
    end
  end

  assign min_tens  = dig[3];
  assign min_ones  = dig[2];
  assign sec_tens  = dig[1];
  assign sec_ones  = dig[0];
  assign state_o   = state;
  assign entry_pos = pos;

endmodule

// File: tb/tb_oven_cook_controller.sv
// Directed bench for oven_cook_controller (TICK_DIV=4, DONE_SECONDS=2, DEBOUNCE_CYCLES=8).
module tb_oven_cook_controller;

`ifdef OVEN_DEBOUNCE_EN
  localparam int HOLD   = 12;
  localparam int SETTLE = 14;
  localparam logic [15:0] FROZEN  = 16'h0007;
  localparam logic [15:0] RESUMED = 16'h0006;
`else
  localparam int HOLD   = 4;
  localparam int SETTLE = 4;
  localparam logic [15:0] FROZEN  = 16'h0009;
  localparam logic [15:0] RESUMED = 16'h0008;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] in;
  logic       pushButton;
  logic       onOff;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       heater_on, alarm;
  logic [2:0] state_o;
  logic [1:0] entry_pos;

  int vectors     = 0;
  int miscompares = 0;

  oven_cook_controller #(
    .TICK_DIV(4),
    .DONE_SECONDS(2),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .pushButton(pushButton), .onOff(onOff),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .heater_on(heater_on), .alarm(alarm), .state_o(state_o), .entry_pos(entry_pos)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] t_now();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] v);
    in = v;
    pushButton = 1'b1;
    step(HOLD);
    pushButton = 1'b0;
    step(SETTLE);
  endtask

  task automatic wait_heater(input string tag, input logic lvl);
    int n = 0;
    while (heater_on !== lvl && n < 200) begin
      step(1);
      n++;
    end
    check(tag, 16'(heater_on), 16'(lvl));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, observed running required done");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int guard;
    rst_n = 1'b0; in = 4'd0; pushButton = 1'b0; onOff = 1'b1;
    step(3);
    check("rst_time",   t_now(), 16'h0000);
    check("rst_heater", 16'(heater_on), 16'd0);
    check("rst_alarm",  16'(alarm), 16'd0);
    rst_n = 1'b1;
    step(3);
    check("rst_state", 16'(state_o), 16'd0);
    check("rst_pos",   16'(entry_pos), 16'd0);

    // Digit entry and clamping
    press(4'd1);
    check("idle_to_entry", 16'(state_o), 16'd1);
    check("entry_clear",   t_now(), 16'h0000);
    press(4'd1); press(4'd2); press(4'd7); press(4'd5);
    check("entry_1255",     t_now(), 16'h1255);
    check("entry_pos_wrap", 16'(entry_pos), 16'd0);
    press(4'd3);
    check("overwrite_mt", t_now(), 16'h3255);
    press(4'hC);
    check("clamp_bcd", t_now(), 16'h3955);
    press(4'd1); press(4'd0); press(4'd0); press(4'd0);
    press(4'hF);
    check("clamp_sec_tens", t_now(), 16'h0050);
    press(4'd2); press(4'd0); press(4'd0); press(4'd1); press(4'd2);
    check("entry_0012", t_now(), 16'h0012);

    // Countdown with borrow
    onOff = 1'b0; step(SETTLE + 2);
    onOff = 1'b1;
    wait_heater("start_heater", 1'b1);
    check("cook_state", 16'(state_o), 16'd2);
    check("cook_t0",    t_now(), 16'h0012);
    step(2);
    check("cook_pre_tick", t_now(), 16'h0012);
    step(1);
    check("cook_first_tick", t_now(), 16'h0011);
    step(8);
    check("cook_borrow_0009", t_now(), 16'h0009);

    // Pause mid-second, freeze, resume with phase kept
    onOff = 1'b0;
    wait_heater("pause_heater", 1'b0);
    check("pause_state",  16'(state_o), 16'd3);
    check("pause_frozen", t_now(), FROZEN);
    step(20);
    check("pause_hold", t_now(), FROZEN);
    onOff = 1'b1;
    wait_heater("resume_heater", 1'b1);
    check("resume_phase", t_now(), RESUMED);

    // Run to DONE, alarm for 8 clocks, back to IDLE
    guard = 0;
    while (alarm !== 1'b1 && guard < 200) begin step(1); guard++; end
    check("done_alarm", 16'(alarm), 16'd1);
    check("done_time",  t_now(), 16'h0000);
    check("done_heater", 16'(heater_on), 16'd0);
    cnt = 0; guard = 0;
    while (alarm === 1'b1 && guard < 50) begin cnt++; step(1); guard++; end
    check("alarm_len",  16'(cnt), 16'd8);
    check("done_idle",  16'(state_o), 16'd0);

    // 01:00 -> 00:59, then pause and cancel
    press(4'd0);
    press(4'd0); press(4'd1); press(4'd0); press(4'd0);
    check("entry_0100", t_now(), 16'h0100);
    onOff = 1'b0; step(SETTLE + 2);
    onOff = 1'b1;
    wait_heater("start2_heater", 1'b1);
    step(3);
    check("borrow_0059", t_now(), 16'h0059);
    onOff = 1'b0;
    wait_heater("pause2_heater", 1'b0);
    check("pause2_state", 16'(state_o), 16'd3);
    press(4'd0);
    check("cancel_state", 16'(state_o), 16'd0);
    check("cancel_time",  t_now(), 16'h0000);

    // Zero time does not start
    press(4'd0);
    onOff = 1'b1; step(SETTLE + 2);
    check("zero_state",  16'(state_o), 16'd1);
    check("zero_heater", 16'(heater_on), 16'd0);

    // Collision: key press and onOff rise in the same cycle
    press(4'd0); press(4'd0); press(4'd3);
    check("coll_pos", 16'(entry_pos), 16'd3);
    onOff = 1'b0; step(SETTLE + 2);
    in = 4'd9; pushButton = 1'b1; onOff = 1'b1;
    wait_heater("coll_heater", 1'b1);
    check("coll_state", 16'(state_o), 16'd2);
    check("coll_nowrite", t_now(), 16'h0030);
    pushButton = 1'b0;
    step(2);

    // Asynchronous reset mid-cook
    rst_n = 1'b0;
    #1;
    check("arst_heater", 16'(heater_on), 16'd0);
    check("arst_state",  16'(state_o), 16'd0);
    check("arst_time",   t_now(), 16'h0000);
    check("arst_pos",    16'(entry_pos), 16'd0);
    step(2);
    rst_n = 1'b1;
    step(3);

`ifdef OVEN_DEBOUNCE_EN
    // Glitch rejection and a clean press
    press(4'd0);
    in = 4'd7; pushButton = 1'b1; step(3); pushButton = 1'b0; step(20);
    check("glitch_pos",  16'(entry_pos), 16'd0);
    check("glitch_time", t_now(), 16'h0000);
    press(4'd7);
    check("clean_time", t_now(), 16'h7000);
    check("clean_pos",  16'(entry_pos), 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
